// File: rtl/pux_si_mc.sv
// -----------------------------------------------------------------------------
// pux_si_mc -- multi-channel stream-in front end for the PUX crypto core.
//
// Opcodes are buffered in a small FIFO and executed one at a time. For each
// opcode the block pulses stream_request, then copies NWORDS words from every
// operand channel selected by the opcode's low NCH bits into the core operand
// RAM port. Channels are loaded in ascending index order. One status word is
// returned per opcode.
//
// Optional feature macro: PUX_SI_TIMEOUT_EN
//   defined   : an idle counter aborts a stalled LOAD after TMO_CYC cycles
//               without a beat and flags the status word.
//   undefined : no counter, LOAD waits indefinitely, timeout flag is 0.
//
// Ports
//   axis_clk, axis_rst      clock (rising edge), asynchronous active-high reset
//   axis_opcode_*           opcode stream in (ready = FIFO not full)
//   axis_op_*               NCH operand streams in, channel c at [c*DATAW +: DATAW]
//   axis_status_*           status stream out, one word per opcode
//   stream_request          one-cycle pulse per started opcode
//   core_wr_*               operand RAM write port (en/ch/addr/data)
//
// Status word: [OPCW-1:0] opcode, [OPCW] timeout, [OPCW+1] empty mask.
// Requires OPFIFOW >= 1, OPCW > NCH, DATAW >= OPCW+2.
// -----------------------------------------------------------------------------
module pux_si_mc #(
  parameter int OPCW    = 8,
  parameter int DATAW   = 16,
  parameter int NCH     = 3,
  parameter int NWORDS  = 16,
  parameter int OPFIFOW = 3,
  parameter int TMO_CYC = 255,
  localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int AW     = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic                 axis_clk,
  input  logic                 axis_rst,
  input  logic [OPCW-1:0]      axis_opcode_data,
  input  logic                 axis_opcode_valid,
  output logic                 axis_opcode_ready,
  input  logic [NCH*DATAW-1:0] axis_op_data,
  input  logic [NCH-1:0]       axis_op_valid,
  output logic [NCH-1:0]       axis_op_ready,
  output logic [DATAW-1:0]     axis_status_data,
  output logic                 axis_status_valid,
  input  logic                 axis_status_ready,
  output logic                 stream_request,
  output logic                 core_wr_en,
  output logic [CHW-1:0]       core_wr_ch,
  output logic [AW-1:0]        core_wr_addr,
  output logic [DATAW-1:0]     core_wr_data
);

  localparam int DEPTH = 2 ** OPFIFOW;
  localparam int PW    = OPFIFOW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_LOAD  = 2'd2,
    S_STAT  = 2'd3
  } state_t;

  // Lowest set bit of mask at or above index lo; MSB of the result is "found".
  function automatic logic [CHW:0] first_at_or_above(input logic [NCH-1:0] mask,
                                                     input int             lo);
    logic [CHW:0] res;
    res = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= lo)) res = {1'b1, CHW'(i)};
    end
    return res;
  endfunction

  function automatic logic [DATAW-1:0] make_status(input logic [OPCW-1:0] op,
                                                   input logic            tmo,
                                                   input logic            empty_mask);
    logic [DATAW-1:0] s;
    s              = '0;
    s[OPCW-1:0]    = op;
    s[OPCW]        = tmo;
    s[OPCW+1]      = empty_mask;
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Opcode FIFO
  // ---------------------------------------------------------------------------
  logic [OPCW-1:0] r_fifo [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic            r_live;   // holds opcode_ready low until the first clock after reset
  logic            w_empty;
  logic            w_full;
  logic            w_push;

  assign w_empty           = (r_wptr == r_rptr);
  assign w_full            = (r_wptr[PW-1] != r_rptr[PW-1]) &&
                             (r_wptr[PW-2:0] == r_rptr[PW-2:0]);
  assign axis_opcode_ready = r_live && !w_full;
  assign w_push            = axis_opcode_valid && axis_opcode_ready;

  // NOTE: the storage array has no reset; only the pointers define what is
  // valid, and leaving the RAM unreset lets it map onto plain memory cells.
  always_ff @(posedge axis_clk) begin
    if (w_push) r_fifo[r_wptr[PW-2:0]] <= axis_opcode_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      r_wptr <= '0;
      r_live <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_push) r_wptr <= r_wptr + PW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer state and channel datapath
  // ---------------------------------------------------------------------------
  state_t           r_state;
  logic [OPCW-1:0]  r_op;
  logic [CHW-1:0]   r_ch;
  logic [AW-1:0]    r_wcnt;
  logic             r_stream_request;
  logic             r_status_valid;
  logic [DATAW-1:0] r_status_data;

  logic [CHW:0]     w_first;
  logic [CHW:0]     w_next;
  logic [NCH-1:0]   w_ready;
  logic             w_ch_valid;
  logic [DATAW-1:0] w_ch_data;
  logic             w_beat;
  logic             w_last;
  logic             w_tmo;

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    w_first    = first_at_or_above(r_op[NCH-1:0], 0);
    w_next     = first_at_or_above(r_op[NCH-1:0], int'(r_ch) + 1);
    w_ready    = '0;
    w_ch_valid = 1'b0;
    w_ch_data  = '0;
    for (int c = 0; c < NCH; c++) begin
      if (r_ch == CHW'(c)) begin
        w_ready[c] = (r_state == S_LOAD);
        w_ch_valid = axis_op_valid[c];
        w_ch_data  = axis_op_data[c*DATAW +: DATAW];
      end
    end
  end

  assign w_beat = (r_state == S_LOAD) && w_ch_valid;
  assign w_last = (r_wcnt == AW'(NWORDS - 1));

`ifdef PUX_SI_TIMEOUT_EN
  localparam int TW = (TMO_CYC > 1) ? $clog2(TMO_CYC + 1) : 1;

  logic [TW-1:0] r_idle;

  // Fires on the TMO_CYC-th consecutive LOAD cycle without a beat.
  assign w_tmo = (r_state == S_LOAD) && !w_beat && (r_idle == TW'(TMO_CYC - 1));

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      r_idle <= '0;
    end else if ((r_state != S_LOAD) || w_beat || w_tmo) begin
      // Held at zero outside LOAD, so LOAD entry always starts a fresh count.
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + TW'(1);
    end
  end
`else
  // Constant 0: TMO_CYC is never negative.
  assign w_tmo = (TMO_CYC < 0);
`endif

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      r_state          <= S_IDLE;
      r_rptr           <= '0;
      r_op             <= '0;
      r_ch             <= '0;
      r_wcnt           <= '0;
      r_stream_request <= 1'b0;
      r_status_valid   <= 1'b0;
      r_status_data    <= '0;
    end else begin
      r_stream_request <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_op             <= r_fifo[r_rptr[PW-2:0]];
            r_rptr           <= r_rptr + PW'(1);
            r_stream_request <= 1'b1;   // visible for exactly the FETCH cycle
            r_state          <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (w_first[CHW]) begin
            r_ch    <= w_first[CHW-1:0];
            r_wcnt  <= '0;
            r_state <= S_LOAD;
          end else begin
            r_status_data  <= make_status(r_op, 1'b0, 1'b1);
            r_status_valid <= 1'b1;
            r_state        <= S_STAT;
          end
        end
        S_LOAD: begin
          if (w_beat) begin
            if (w_last) begin
              r_wcnt <= '0;
              if (w_next[CHW]) begin
                r_ch <= w_next[CHW-1:0];
              end else begin
                r_status_data  <= make_status(r_op, 1'b0, 1'b0);
                r_status_valid <= 1'b1;
                r_state        <= S_STAT;
              end
            end else begin
              r_wcnt <= r_wcnt + AW'(1);
            end
          end else if (w_tmo) begin
            // Abandon the remaining words; no further writes for this opcode.
            r_wcnt         <= '0;
            r_status_data  <= make_status(r_op, 1'b1, 1'b0);
            r_status_valid <= 1'b1;
            r_state        <= S_STAT;
          end
        end
        S_STAT: begin
          if (axis_status_ready) begin
            r_status_valid <= 1'b0;
            r_status_data  <= '0;
            r_state        <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign axis_op_ready     = w_ready;
  assign axis_status_valid = r_status_valid;
  assign axis_status_data  = r_status_data;
  assign stream_request    = r_stream_request;

  // Write port follows the beat combinationally; fields are zero when idle.
  assign core_wr_en   = w_beat;
  assign core_wr_ch   = w_beat ? r_ch      : '0;
  assign core_wr_addr = w_beat ? r_wcnt    : '0;
  assign core_wr_data = w_beat ? w_ch_data : '0;

endmodule

// File: tb/tb_pux_si_mc.sv
// -----------------------------------------------------------------------------
// tb_pux_si_mc -- self-checking bench for pux_si_mc.
// Expected writes and status words are queued when an opcode is issued and
// compared as the DUT produces them. A background driver feeds each operand
// channel from its own word queue with a configurable valid probability.
// -----------------------------------------------------------------------------
module tb_pux_si_mc;

  localparam int OPCW    = 8;
  localparam int DATAW   = 16;
  localparam int NCH     = 3;
  localparam int NWORDS  = 16;
  localparam int OPFIFOW = 3;
  localparam int TMO_CYC = 255;
  localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW      = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  logic                 axis_clk = 1'b0;
  logic                 axis_rst = 1'b1;
  logic [OPCW-1:0]      axis_opcode_data = '0;
  logic                 axis_opcode_valid = 1'b0;
  logic                 axis_opcode_ready;
  logic [NCH*DATAW-1:0] axis_op_data = '0;
  logic [NCH-1:0]       axis_op_valid = '0;
  logic [NCH-1:0]       axis_op_ready;
  logic [DATAW-1:0]     axis_status_data;
  logic                 axis_status_valid;
  logic                 axis_status_ready = 1'b0;
  logic                 stream_request;
  logic                 core_wr_en;
  logic [CHW-1:0]       core_wr_ch;
  logic [AW-1:0]        core_wr_addr;
  logic [DATAW-1:0]     core_wr_data;

  always #5 axis_clk = ~axis_clk;

  pux_si_mc #(
    .OPCW(OPCW), .DATAW(DATAW), .NCH(NCH), .NWORDS(NWORDS),
    .OPFIFOW(OPFIFOW), .TMO_CYC(TMO_CYC)
  ) dut (
    .axis_clk          (axis_clk),
    .axis_rst          (axis_rst),
    .axis_opcode_data  (axis_opcode_data),
    .axis_opcode_valid (axis_opcode_valid),
    .axis_opcode_ready (axis_opcode_ready),
    .axis_op_data      (axis_op_data),
    .axis_op_valid     (axis_op_valid),
    .axis_op_ready     (axis_op_ready),
    .axis_status_data  (axis_status_data),
    .axis_status_valid (axis_status_valid),
    .axis_status_ready (axis_status_ready),
    .stream_request    (stream_request),
    .core_wr_en        (core_wr_en),
    .core_wr_ch        (core_wr_ch),
    .core_wr_addr      (core_wr_addr),
    .core_wr_data      (core_wr_data)
  );

  typedef struct {
    int               ch;
    int               addr;
    logic [DATAW-1:0] data;
  } wr_t;

  wr_t              exp_wr[$];
  logic [DATAW-1:0] exp_st[$];
  logic [DATAW-1:0] ch_q[NCH][$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_wr  = 0;
  int n_st  = 0;
  int n_req = 0;
  int n_bready = 0;
  int req_cyc = 0;
  int req_cyc_prev = 0;
  int wr_cyc = 0;
  int st_cyc = 0;
  int valid_pct  = 100;
  int sready_pct = 100;

  // Monitor on the falling edge, driver update 1 time unit after the rising edge.
  initial begin
    logic [NCH-1:0] fire;
    logic           sfire;
    wr_t            e;
    logic [DATAW-1:0] s;
    forever begin
      @(negedge axis_clk);
      cyc++;
      fire  = axis_op_valid & axis_op_ready;
      sfire = axis_status_valid && axis_status_ready;
      if (stream_request) begin
        n_req++;
        req_cyc_prev = req_cyc;
        req_cyc      = cyc;
      end
      if (axis_op_ready[1]) n_bready++;
      if (core_wr_en) begin
        n_wr++;
        wr_cyc = cyc;
        total++;
        if (exp_wr.size() == 0) begin
          bad++;
          $display("FAIL write_unexpected got ch=%0d addr=%0d data=%h, want no write",
                   core_wr_ch, core_wr_addr, core_wr_data);
        end else begin
          e = exp_wr.pop_front();
          if (int'(core_wr_ch) !== e.ch || int'(core_wr_addr) !== e.addr ||
              core_wr_data !== e.data) begin
            bad++;
            $display("FAIL write got ch=%0d addr=%0d data=%h, want ch=%0d addr=%0d data=%h",
                     core_wr_ch, core_wr_addr, core_wr_data, e.ch, e.addr, e.data);
          end
        end
      end
      if (sfire) begin
        n_st++;
        st_cyc = cyc;
        total++;
        if (exp_st.size() == 0) begin
          bad++;
          $display("FAIL status_unexpected got=%h, want no status", axis_status_data);
        end else begin
          s = exp_st.pop_front();
          if (axis_status_data !== s) begin
            bad++;
            $display("FAIL status_word got=%h want=%h", axis_status_data, s);
          end
        end
      end
      @(posedge axis_clk);
      #1;
      for (int c = 0; c < NCH; c++) begin
        if (fire[c] && ch_q[c].size() > 0) void'(ch_q[c].pop_front());
      end
      for (int c = 0; c < NCH; c++) begin
        if (ch_q[c].size() > 0 && int'($urandom_range(0, 99)) < valid_pct) begin
          axis_op_valid[c]                = 1'b1;
          axis_op_data[c*DATAW +: DATAW]  = ch_q[c][0];
        end else begin
          axis_op_valid[c]                = 1'b0;
          axis_op_data[c*DATAW +: DATAW]  = '0;
        end
      end
      axis_status_ready = (int'($urandom_range(0, 99)) < sready_pct);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  // Queue the expected effects of an opcode, then hand it to the DUT.
  task automatic push_op(input logic [OPCW-1:0] op, input int nw, input bit tmo);
    logic [DATAW-1:0] d;
    logic [DATAW-1:0] s;
    int guard;
    for (int c = 0; c < NCH; c++) begin
      if (op[c]) begin
        for (int w = 0; w < nw; w++) begin
          d = DATAW'($urandom);
          ch_q[c].push_back(d);
          exp_wr.push_back('{c, w, d});
        end
      end
    end
    s             = '0;
    s[OPCW-1:0]   = op;
    s[OPCW]       = tmo;
    s[OPCW+1]     = (op[NCH-1:0] == '0);
    exp_st.push_back(s);
    @(negedge axis_clk);
    axis_opcode_data  = op;
    axis_opcode_valid = 1'b1;
    guard = 0;
    while (!axis_opcode_ready && guard < 20000) begin
      @(negedge axis_clk);
      guard++;
    end
    if (guard >= 20000) begin
      total++;
      bad++;
      $display("FAIL opcode_accept got=stuck want=accepted op=%h", op);
    end
    @(posedge axis_clk);
    #1;
    axis_opcode_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int guard;
    guard = 0;
    while ((exp_wr.size() != 0 || exp_st.size() != 0) && guard < budget) begin
      @(negedge axis_clk);
      guard++;
    end
    total++;
    if (exp_wr.size() != 0 || exp_st.size() != 0) begin
      bad++;
      $display("FAIL %s_drain got writes_left=%0d status_left=%0d want 0 0",
               name, exp_wr.size(), exp_st.size());
    end
    repeat (3) @(negedge axis_clk);
  endtask

  task automatic test_reset;
    #2;
    total++;
    if ({axis_opcode_ready, axis_op_ready, axis_status_data, axis_status_valid,
         stream_request, core_wr_en, core_wr_ch, core_wr_addr, core_wr_data} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got nonzero outputs want all zero");
    end
    repeat (2) @(negedge axis_clk);
    axis_rst = 1'b0;
    #1;
    total++;
    if (axis_opcode_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready_before_clock got=%b want=0", axis_opcode_ready);
    end
    @(negedge axis_clk);
    total++;
    if (axis_opcode_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready_after_clock got=%b want=1", axis_opcode_ready);
    end
  endtask

  task automatic test_reset_mid_load;
    int wr0, st0, req0, guard;
    valid_pct  = 100;
    sready_pct = 100;
    wr0 = n_wr;
    push_op(8'h07, NWORDS, 1'b0);
    guard = 0;
    while (n_wr < wr0 + 5 && guard < 200) begin
      @(negedge axis_clk);
      guard++;
    end
    total++;
    if (n_wr < wr0 + 5) begin
      bad++;
      $display("FAIL midload_writes got=%0d want>=5", n_wr - wr0);
    end
    #1;
    axis_rst = 1'b1;
    #1;
    total++;
    if ({axis_opcode_ready, axis_op_ready, axis_status_data, axis_status_valid,
         stream_request, core_wr_en, core_wr_ch, core_wr_addr, core_wr_data} !== '0) begin
      bad++;
      $display("FAIL midload_async_reset got nonzero outputs want all zero");
    end
    @(posedge axis_clk);
    #2;
    exp_wr.delete();
    exp_st.delete();
    for (int c = 0; c < NCH; c++) ch_q[c].delete();
    repeat (2) @(negedge axis_clk);
    axis_rst = 1'b0;
    wr0  = n_wr;
    st0  = n_st;
    req0 = n_req;
    #1;
    total++;
    if (axis_opcode_ready !== 1'b0) begin
      bad++;
      $display("FAIL midload_ready_release got=%b want=0", axis_opcode_ready);
    end
    @(negedge axis_clk);
    total++;
    if (axis_opcode_ready !== 1'b1) begin
      bad++;
      $display("FAIL midload_ready_next got=%b want=1", axis_opcode_ready);
    end
    repeat (20) @(negedge axis_clk);
    total++;
    if (n_wr != wr0 || n_st != st0 || n_req != req0) begin
      bad++;
      $display("FAIL midload_quiet got wr=%0d st=%0d req=%0d want 0 0 0",
               n_wr - wr0, n_st - st0, n_req - req0);
    end
  endtask

  task automatic test_fifo_full;
    valid_pct  = 100;
    sready_pct = 0;
    repeat (2) @(negedge axis_clk);
    for (int i = 0; i < 9; i++) push_op(OPCW'(i << NCH), NWORDS, 1'b0);
    @(negedge axis_clk);
    total++;
    if (axis_opcode_ready !== 1'b0 || axis_status_valid !== 1'b1) begin
      bad++;
      $display("FAIL fifo_full got ready=%b status_valid=%b want 0 1",
               axis_opcode_ready, axis_status_valid);
    end
    sready_pct = 100;
    @(negedge axis_clk);
    sready_pct = 0;
    @(negedge axis_clk);
    total++;
    if (axis_opcode_ready !== 1'b0) begin
      bad++;
      $display("FAIL fifo_full_before_pop got=%b want=0", axis_opcode_ready);
    end
    @(negedge axis_clk);
    total++;
    if (axis_opcode_ready !== 1'b1) begin
      bad++;
      $display("FAIL fifo_free_one got=%b want=1", axis_opcode_ready);
    end
    sready_pct = 100;
    wait_drain("fifo_full", 2000);
  endtask

  task automatic test_mask_a_m;
    int wr0, req0, b0;
    valid_pct  = 100;
    sready_pct = 100;
    wr0 = n_wr; req0 = n_req; b0 = n_bready;
    push_op(8'h05, NWORDS, 1'b0);
    wait_drain("mask_a_m", 2000);
    total++;
    if (n_req - req0 != 1 || n_wr - wr0 != 2 * NWORDS || n_bready != b0) begin
      bad++;
      $display("FAIL mask_a_m_counts got req=%0d wr=%0d bready=%0d want 1 %0d 0",
               n_req - req0, n_wr - wr0, n_bready - b0, 2 * NWORDS);
    end
  endtask

  task automatic test_empty_mask;
    int wr0, req0;
    wr0 = n_wr; req0 = n_req;
    push_op(8'h00, NWORDS, 1'b0);
    wait_drain("empty_mask", 200);
    total++;
    if (n_req - req0 != 1 || n_wr != wr0) begin
      bad++;
      $display("FAIL empty_mask_counts got req=%0d wr=%0d want 1 0", n_req - req0, n_wr - wr0);
    end
  endtask

  task automatic test_back_to_back;
    valid_pct  = 100;
    sready_pct = 100;
    push_op(8'hA3, NWORDS, 1'b0);
    push_op(8'h5B, NWORDS, 1'b0);
    wait_drain("b2b_load", 2000);
    total++;
    if (req_cyc - req_cyc_prev != 3 + 2 * NWORDS) begin
      bad++;
      $display("FAIL b2b_load_spacing got=%0d want=%0d", req_cyc - req_cyc_prev, 3 + 2 * NWORDS);
    end
    push_op(8'h80, NWORDS, 1'b0);
    push_op(8'h40, NWORDS, 1'b0);
    wait_drain("b2b_empty", 200);
    total++;
    if (req_cyc - req_cyc_prev != 3) begin
      bad++;
      $display("FAIL b2b_empty_spacing got=%0d want=3", req_cyc - req_cyc_prev);
    end
  endtask

  task automatic test_back_pressure;
    int st0;
    valid_pct  = 60;
    sready_pct = 60;
    st0 = n_st;
    for (int i = 0; i < 100; i++) push_op(OPCW'($urandom), NWORDS, 1'b0);
    wait_drain("back_pressure", 40000);
    total++;
    if (n_st - st0 != 100) begin
      bad++;
      $display("FAIL back_pressure_status_count got=%0d want=100", n_st - st0);
    end
    valid_pct  = 100;
    sready_pct = 100;
  endtask

`ifdef PUX_SI_TIMEOUT_EN
  task automatic test_timeout;
    int wr0;
    valid_pct  = 100;
    sready_pct = 100;
    wr0 = n_wr;
    push_op(8'h01, 4, 1'b1);
    wait_drain("timeout", 2000);
    total++;
    if (n_wr - wr0 != 4 || st_cyc - wr_cyc != TMO_CYC + 1) begin
      bad++;
      $display("FAIL timeout got wr=%0d gap=%0d want 4 %0d",
               n_wr - wr0, st_cyc - wr_cyc, TMO_CYC + 1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid_load();
    test_fifo_full();
    test_mask_a_m();
    test_empty_mask();
    test_back_to_back();
    test_back_pressure();
`ifdef PUX_SI_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
